// File: rtl/cfg_loader_pkg.sv
// cfg_loader_pkg: word width shared by the loader and the switch-box tiles, plus loader FSM states
package cfg_loader_pkg;
  localparam int WORD_W = 32;
  typedef enum logic [1:0] {IDLE, WAIT_WORD, SHIFT, DONE} state_t;
endpackage

// File: rtl/config_loader.sv
// config_loader: shifts configuration words down a switch-box programming chain while capturing its prior contents
module config_loader
  import cfg_loader_pkg::*;
#(
  parameter int NUM_WORDS = 4
) (
  input  logic              prog_clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              chain_dout,
  output logic              chain_en,
  input  logic              chain_din,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid,
  output logic              busy,
  output logic              done
);
  localparam int WCW = NUM_WORDS > 1 ? $clog2(NUM_WORDS) : 1;
  state_t state, state_nx;
  logic [WCW-1:0] word_cnt;
  logic [4:0] bit_cnt;
  logic [WORD_W-1:0] tx, rx;
  logic xfer, last_bit, last_word;
  assign xfer = cfg_valid && cfg_ready;
  assign last_bit = bit_cnt == 5'd31;
  assign last_word = word_cnt == WCW'(NUM_WORDS - 1);
  always_ff @(posedge prog_clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      state_nx = start ? WAIT_WORD : IDLE;
      WAIT_WORD: state_nx = xfer ? SHIFT : WAIT_WORD;
      SHIFT:     state_nx = !last_bit ? SHIFT : last_word ? DONE : WAIT_WORD;
      default:   state_nx = IDLE;
    endcase
  end
  always_comb begin
    cfg_ready  = state == WAIT_WORD;
    chain_en   = state == SHIFT;
    chain_dout = chain_en && tx[0];
    busy       = state != IDLE;
    done       = state == DONE;
  end
  always_ff @(posedge prog_clk or posedge rst)
    if (rst) begin
      word_cnt <= '0;
      bit_cnt  <= '0;
      tx       <= '0;
      rx       <= '0;
      rb_data  <= '0;
      rb_valid <= 1'b0;
    end else begin
      rb_valid <= chain_en && last_bit;
      if (state == IDLE && start) word_cnt <= '0;
      if (xfer) begin
        tx      <= cfg_data;
        bit_cnt <= '0;
      end
      if (chain_en) begin
        tx      <= tx >> 1;
        rx      <= {chain_din, rx[WORD_W-1:1]};
        bit_cnt <= bit_cnt + 5'd1;
        if (last_bit) begin
          rb_data <= {chain_din, rx[WORD_W-1:1]};
          if (!last_word) word_cnt <= word_cnt + 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_config_loader.sv
// tb_config_loader: directed checks of config_loader driving a 4-tile chain model, plus a single-word instance
module tb_config_loader;
  logic prog_clk = 1'b0, rst = 1'b1, start = 1'b0, cfg_valid = 1'b0;
  logic [31:0] cfg_data = '0;
  logic cfg_ready, chain_dout, chain_en, chain_din, rb_valid, busy, done;
  logic [31:0] rb_data;
  logic start1 = 1'b0, valid1 = 1'b0, cdin1 = 1'b0;
  logic [31:0] data1 = '0;
  logic ready1, dout1, en1, rbv1, busy1, done1;
  logic [31:0] rbd1;
  logic [31:0] tile [4] = '{default: 32'h0};
  logic [31:0] rb [8];
  logic [31:0] seq;
  int total = 0, bad = 0;
  int rbn, donen, cyc;

  config_loader #(.NUM_WORDS(4)) dut (
    .prog_clk(prog_clk), .rst(rst), .start(start), .cfg_data(cfg_data),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .chain_dout(chain_dout),
    .chain_en(chain_en), .chain_din(chain_din), .rb_data(rb_data),
    .rb_valid(rb_valid), .busy(busy), .done(done)
  );

  config_loader #(.NUM_WORDS(1)) dut1 (
    .prog_clk(prog_clk), .rst(rst), .start(start1), .cfg_data(data1),
    .cfg_valid(valid1), .cfg_ready(ready1), .chain_dout(dout1),
    .chain_en(en1), .chain_din(cdin1), .rb_data(rbd1),
    .rb_valid(rbv1), .busy(busy1), .done(done1)
  );

  always #5 prog_clk = ~prog_clk;

  // tile 0 is the chain head, tile 3 the tail feeding chain_din
  assign chain_din = tile[3][0];
  always @(posedge prog_clk)
    if (chain_en) begin
      tile[0] <= {chain_dout, tile[0][31:1]};
      for (int i = 1; i < 4; i++) tile[i] <= {tile[i-1][0], tile[i][31:1]};
    end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ready"}, cfg_ready, 0);
    chk({tag, "_en"}, chain_en, 0);
    chk({tag, "_dout"}, chain_dout, 0);
    chk({tag, "_rbdata"}, rb_data, 0);
    chk({tag, "_rbvalid"}, rb_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  // n counts edges since start was driven; cyc is the inclusive start..done cycle count
  task automatic load(input logic [31:0] w0, w1, w2, w3, input int stall, input int start_at,
                      input int rst_at);
    logic [31:0] w [4];
    int idx, sl, n;
    logic xf;
    w = '{w0, w1, w2, w3};
    idx = 0; sl = 0; rbn = 0; donen = 0; cyc = 0;
    cfg_data = w[0];
    cfg_valid = 1'b1;
    start = 1'b1;
    @(posedge prog_clk); #1;
    start = 1'b0;
    n = 1;
    while (!done && n < 800) begin
      if (n == rst_at) begin
        chk("en_before_rst", chain_en, 1);
        rst = 1'b1;
        #1;
        chk_idle_outputs("mid_rst");
        #2 rst = 1'b0;
        cfg_valid = 1'b0;
        return;
      end
      if (n == start_at) begin
        chk("mid_start_in_shift", chain_en, 1);
        start = 1'b1;
      end
      if (cfg_ready && sl > 0) begin
        cfg_valid = 1'b0;
        sl--;
        chk("stall_en_low", chain_en, 0);
      end else cfg_valid = 1'b1;
      xf = cfg_valid && cfg_ready;
      @(posedge prog_clk); #1;
      n++;
      start = 1'b0;
      if (xf) begin
        idx++;
        cfg_data = w[idx % 4];
        sl = stall;
      end
      if (rb_valid) begin
        rb[rbn % 8] = rb_data;
        rbn++;
      end
    end
    cfg_valid = 1'b0;
    chk("done_seen", done, 1);
    cyc = n + 1;
    if (done) donen = 1;
    @(posedge prog_clk); #1;
    chk("busy_after_done", busy, 0);
    chk("done_one_cycle", done, 0);
    repeat (3) begin
      @(posedge prog_clk); #1;
      if (done) donen++;
      if (rb_valid) rbn++;
    end
  endtask

  task automatic chk_tiles(input string tag, input logic [31:0] t0, t1, t2, t3);
    chk({tag, "_tile0"}, tile[0], t0);
    chk({tag, "_tile1"}, tile[1], t1);
    chk({tag, "_tile2"}, tile[2], t2);
    chk({tag, "_tile3"}, tile[3], t3);
  endtask

  initial begin
    int n, k, r1;
    repeat (2) @(posedge prog_clk);
    #1;
    chk_idle_outputs("reset");
    chk("reset_busy1", busy1, 0);
    chk("reset_ready1", ready1, 0);
    rst = 1'b0;
    @(posedge prog_clk); #1;

    load(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 0, 0, 0);
    chk("load1_cycles", cyc, 134);
    chk("load1_done_count", donen, 1);
    chk_tiles("load1", 32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111);

    load(32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 0, 0, 0);
    chk("rb_count", rbn, 4);
    chk("rb0", rb[0], 32'h11111111);
    chk("rb1", rb[1], 32'h22222222);
    chk("rb2", rb[2], 32'h33333333);
    chk("rb3", rb[3], 32'h44444444);
    chk("rb_hold", rb_data, 32'h44444444);
    chk_tiles("load2", 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5);

    load(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 10, 0, 0);
    chk("stall_cycles", cyc, 164);
    chk_tiles("stall", 32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111);

    load(32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888, 0, 40, 0);
    chk("mid_start_rb_count", rbn, 4);
    chk("mid_start_done_count", donen, 1);
    chk("mid_start_cycles", cyc, 134);
    chk("mid_start_rb0", rb[0], 32'h11111111);
    chk_tiles("mid_start", 32'h88888888, 32'h77777777, 32'h66666666, 32'h55555555);

    load(32'hDEADBEEF, 32'hCAFEF00D, 32'h01234567, 32'h89ABCDEF, 0, 0, 85);
    @(posedge prog_clk); #1;
    chk("post_rst_busy", busy, 0);
    load(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 0, 0, 0);
    chk("post_rst_cycles", cyc, 134);
    chk_tiles("post_rst", 32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111);

    seq = '0;
    k = 0;
    r1 = 0;
    data1 = 32'h80000001;
    valid1 = 1'b1;
    start1 = 1'b1;
    @(posedge prog_clk); #1;
    start1 = 1'b0;
    n = 1;
    while (!done1 && n < 100) begin
      if (en1 && k < 32) begin
        seq[k] = dout1;
        k++;
      end
      @(posedge prog_clk); #1;
      n++;
      if (rbv1) r1++;
    end
    valid1 = 1'b0;
    chk("single_done", done1, 1);
    chk("single_cycles", n + 1, 35);
    chk("single_shift_count", k, 32);
    chk("single_dout_seq", seq, 32'h80000001);
    chk("single_rb_count", r1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/config_loader.md
CONFIG_LOADER -- requirements
Module: config_loader

Interface
REQ-001 The block SHALL have parameter NUM_WORDS, default 4, giving the number of 32-bit configuration words per load (one per switch-box tile on the chain); legal range 1..256.
REQ-002 The block SHALL have port prog_clk  in  1  single clock; all state advances on its rising edge.
REQ-003 The block SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-004 The block SHALL have port start  in  1  one-cycle request to begin a load of NUM_WORDS words.
REQ-005 The block SHALL have port cfg_data  in  32  configuration word, bit 0 shifted first.
REQ-006 The block SHALL have ports cfg_valid  in  1 and cfg_ready  out  1, forming the word handshake; a transfer occurs when both are high on a clock edge.
REQ-007 The block SHALL have port chain_dout  out  1  serial data driven to the first tile's programming input.
REQ-008 The block SHALL have port chain_en  out  1  shift enable driven to every tile's programming enable.
REQ-009 The block SHALL have port chain_din  in  1  serial data returned from the last tile's programming output.
REQ-010 The block SHALL have ports rb_data  out  32 and rb_valid  out  1: the readback word and its one-cycle strobe; there is no backpressure.
REQ-011 The block SHALL have ports busy  out  1 (high in any state other than IDLE) and done  out  1 (one-cycle completion pulse).

Function
REQ-012 The FSM SHALL have states IDLE, WAIT_WORD, SHIFT and DONE.
REQ-013 IDLE SHALL move to WAIT_WORD when start=1, clearing word_cnt; start SHALL be ignored in every other state.
REQ-014 In WAIT_WORD, cfg_ready SHALL be 1; a transfer SHALL load the tx shifter with cfg_data, clear bit_cnt and move to SHIFT. cfg_ready SHALL be 0 in all other states.
REQ-015 In SHIFT, chain_en SHALL be 1 and chain_dout SHALL equal tx shifter bit 0; each cycle the tx shifter SHALL shift right and bit_cnt SHALL increment.
REQ-016 In SHIFT, each cycle the rx shifter SHALL capture chain_din as {chain_din, rx[31:1]}, so that it records the bit leaving the chain on that same edge.
REQ-017 On the cycle with bit_cnt=31, SHIFT SHALL exit to DONE if word_cnt=NUM_WORDS-1, and otherwise to WAIT_WORD with word_cnt incremented.
REQ-018 rb_valid SHALL pulse for exactly one cycle, in the cycle after the 32nd shift of each word; rb_data SHALL hold the completed rx word and remain stable until the next word's strobe.
REQ-019 Readback order SHALL be: rb word k is the prior content of the k-th tile counted from the chain tail. Word 0 sent SHALL finish in the tail tile.
REQ-020 chain_en SHALL be 0 in IDLE, WAIT_WORD and DONE. Gaps between words SHALL NOT corrupt the chain.
REQ-021 DONE SHALL assert done for one cycle and return to IDLE; busy SHALL drop in that IDLE cycle.
REQ-022 Per-word latency SHALL be at least 33 cycles: one handshake cycle plus 32 shift cycles. A full load with cfg_valid held high SHALL take 2 + 33*NUM_WORDS cycles from start to done.
REQ-023 cfg_valid asserted while cfg_ready=0 SHALL have no effect and SHALL NOT be counted.

Reset
REQ-024 While rst=1, all outputs SHALL be 0, including cfg_ready, chain_en, chain_dout, rb_data, rb_valid, busy and done; the FSM SHALL be in IDLE and all counters and shifters SHALL be 0.
REQ-025 Reset asserted mid-SHIFT SHALL immediately force chain_en=0. The partially shifted chain content is not restored; software SHALL reload.

Structure
REQ-026 A shared package cfg_loader_pkg SHALL hold the WORD_W=32 constant and the FSM state enum; the switch-box tile SHALL use the same WORD_W.
REQ-027 bit_cnt SHALL be 5 bits and word_cnt SHALL be clog2(NUM_WORDS) bits with a minimum of 1; no sub-module is required.

Verification
REQ-028 Bench SHALL cover: reset, then start with NUM_WORDS=4 and words 0x11111111, 0x22222222, 0x33333333, 0x44444444 into a chain of 4 tile models -> tail tile holds 0x11111111, head tile holds 0x44444444, and done occurs 134 cycles after start.
REQ-029 Bench SHALL cover: a second load of 0xA5A5A5A5 x4 -> rb words 0x11111111, 0x22222222, 0x33333333, 0x44444444 in that order.
REQ-030 Bench SHALL cover: cfg_valid stalled 10 cycles between words -> chain_en stays low during the stall and final contents are identical to the unstalled case.
REQ-031 Bench SHALL cover: start pulsed during SHIFT -> ignored, with exactly 4 rb_valid pulses and 1 done.
REQ-032 Bench SHALL cover: rst asserted at bit 17 of word 2 -> all outputs 0 the same cycle, busy=0, and a subsequent full load succeeds.
REQ-033 Bench SHALL cover: NUM_WORDS=1 with word 0x80000001 -> chain_dout sequence 1,0,...,0,1 and done after 35 cycles.
